flit_injector: RTL and testbench

- Synthesizable per-port packet source for router and mesh benches and for built-in self-test.
- Accepts a packet command (destination, VC, size, inter-flit gap) and emits a well-formed HEAD/BODY/TAIL or HEADTAIL flit stream in flit_t format on a router input port.
- Obeys per-VC on/off flow control from downstream and reports sent-flit and sent-packet counts for scoreboarding.
- Generalises the hand-driven stimulus to any packet size, gap, VC and destination, with backpressure stalls.

---
 rtl/flit_injector.sv | 189 ++++++++++++++++++
 tb/tb_flit_injector.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_injector.sv
// Per-port packet source: turns one packet command into a HEAD/BODY/TAIL (or HEADTAIL)
// flit stream under per-VC on/off flow control, with flit and packet counters.

package flit_pkg;
   localparam int VC_NUM            = 2;
   localparam int VC_SIZE           = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int DEST_ADDR_SIZE_X  = 4;
   localparam int DEST_ADDR_SIZE_Y  = 4;
   localparam int HEAD_PAYLOAD_SIZE = 8;
   localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

   typedef enum logic [1:0] {
      HEAD     = 2'b00,
      BODY     = 2'b01,
      TAIL     = 2'b10,
      HEADTAIL = 2'b11
   } flit_label_t;

   typedef struct packed {
      logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
      logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
      logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
   } head_data_t;

   typedef union packed {
      head_data_t                head_data;
      logic [FLIT_DATA_SIZE-1:0] bt_pl;
   } flit_data_t;

   typedef struct packed {
      flit_label_t        flit_label;
      logic [VC_SIZE-1:0] vc_id;
      flit_data_t         data;
   } flit_t;
endpackage

module flit_injector
   import flit_pkg::*;
#(
   parameter int MAX_PKT_SIZE = 16,
   parameter int SIZE_W       = $clog2(MAX_PKT_SIZE + 1),
   parameter int GAP_W        = 4,
   parameter int CNT_W        = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start_i,
   input  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i,
   input  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i,
   input  logic [VC_SIZE-1:0]          vc_i,
   input  logic [SIZE_W-1:0]           pkt_size_i,
   input  logic [GAP_W-1:0]            gap_i,
   input  logic [VC_NUM-1:0]           on_off_i,
   output flit_t                       data_o,
   output logic                        valid_flit_o,
   output logic                        busy_o,
   output logic                        pkt_done_o,
   output logic                        cmd_error_o,
   output logic [CNT_W-1:0]            flits_sent_o,
   output logic [CNT_W-1:0]            pkts_sent_o
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      GAP  = 2'b10
   } state_t;

   localparam logic [SIZE_W-1:0] SIZE_ONE = SIZE_W'(1);
   localparam logic [SIZE_W-1:0] SIZE_MAX = SIZE_W'(MAX_PKT_SIZE);

   state_t                      state_r;
   logic [DEST_ADDR_SIZE_X-1:0] x_r;
   logic [DEST_ADDR_SIZE_Y-1:0] y_r;
   logic [VC_SIZE-1:0]          vc_r;
   logic [SIZE_W-1:0]           size_r;
   logic [SIZE_W-1:0]           idx_r;
   logic [GAP_W-1:0]            gap_r;
   logic [GAP_W-1:0]            gap_cnt_r;
   logic [CNT_W-1:0]            seq_r;
   logic                        cmd_ok_s;

   assign cmd_ok_s = (pkt_size_i != {SIZE_W{1'b0}}) && (pkt_size_i <= SIZE_MAX);

   // Head flits carry the packet sequence number; body/tail flits carry their index.
   function automatic flit_t make_flit(
      input logic [SIZE_W-1:0]           idx,
      input logic [SIZE_W-1:0]           size,
      input logic [VC_SIZE-1:0]          vc,
      input logic [DEST_ADDR_SIZE_X-1:0] x,
      input logic [DEST_ADDR_SIZE_Y-1:0] y,
      input logic [CNT_W-1:0]            seq
   );
      flit_t f;
      f       = '0;
      f.vc_id = vc;
      if (idx == {SIZE_W{1'b0}}) begin
         f.flit_label             = (size == SIZE_ONE) ? HEADTAIL : HEAD;
         f.data.head_data.x_dest  = x;
         f.data.head_data.y_dest  = y;
         f.data.head_data.head_pl = HEAD_PAYLOAD_SIZE'(seq);
      end else begin
         f.flit_label = (idx == size - SIZE_ONE) ? TAIL : BODY;
         f.data.bt_pl = FLIT_DATA_SIZE'(idx);
      end
      return f;
   endfunction

   // Command FSM, flit generation and statistics counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         x_r          <= '0;
         y_r          <= '0;
         vc_r         <= '0;
         size_r       <= '0;
         idx_r        <= '0;
         gap_r        <= '0;
         gap_cnt_r    <= '0;
         seq_r        <= '0;
         data_o       <= '0;
         valid_flit_o <= 1'b0;
         busy_o       <= 1'b0;
         pkt_done_o   <= 1'b0;
         cmd_error_o  <= 1'b0;
         flits_sent_o <= '0;
         pkts_sent_o  <= '0;
      end else begin
         valid_flit_o <= 1'b0;
         pkt_done_o   <= 1'b0;
         cmd_error_o  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start_i && cmd_ok_s) begin
                  x_r     <= x_dest_i;
                  y_r     <= y_dest_i;
                  vc_r    <= vc_i;
                  size_r  <= pkt_size_i;
                  gap_r   <= gap_i;
                  idx_r   <= '0;
                  busy_o  <= 1'b1;
                  state_r <= SEND;
               end else if (start_i) begin
                  cmd_error_o <= 1'b1;
               end else begin
                  busy_o <= 1'b0;
               end
            end
            SEND: begin
               // A closed VC simply holds the state; there is no stall timeout.
               if (on_off_i[vc_r]) begin
                  valid_flit_o <= 1'b1;
                  data_o       <= make_flit(idx_r, size_r, vc_r, x_r, y_r, seq_r);
                  flits_sent_o <= flits_sent_o + CNT_W'(1);
                  if (idx_r == size_r - SIZE_ONE) begin
                     pkt_done_o  <= 1'b1;
                     pkts_sent_o <= pkts_sent_o + CNT_W'(1);
                     seq_r       <= seq_r + CNT_W'(1);
                     busy_o      <= 1'b0;
                     state_r     <= IDLE;
                  end else begin
                     idx_r <= idx_r + SIZE_ONE;
                     if (gap_r != {GAP_W{1'b0}}) begin
                        gap_cnt_r <= gap_r;
                        state_r   <= GAP;
                     end else begin
                        state_r <= SEND;
                     end
                  end
               end else begin
                  state_r <= SEND;
               end
            end
            GAP: begin
               if (gap_cnt_r == GAP_W'(1)) begin
                  state_r <= SEND;
               end else begin
                  gap_cnt_r <= gap_cnt_r - GAP_W'(1);
               end
            end
            default: begin
               busy_o  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector: stimulus pushes expected flits into a scoreboard
// queue that a negedge monitor drains; timing and counters are checked inline.

module tb_flit_injector;
   import flit_pkg::*;

   localparam int MAX_PKT_SIZE = 16;
   localparam int SIZE_W       = $clog2(MAX_PKT_SIZE + 1);
   localparam int GAP_W        = 4;
   localparam int CNT_W        = 16;

   typedef struct {
      logic [1:0]  label;
      logic        vc;
      logic [15:0] pl;
      logic [3:0]  x;
      logic [3:0]  y;
      logic        done;
   } exp_t;

   logic                        clk = 1'b0;
   logic                        rst = 1'b0;
   logic                        start_i = 1'b0;
   logic [DEST_ADDR_SIZE_X-1:0] x_dest_i = '0;
   logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i = '0;
   logic [VC_SIZE-1:0]          vc_i = '0;
   logic [SIZE_W-1:0]           pkt_size_i = '0;
   logic [GAP_W-1:0]            gap_i = '0;
   logic [VC_NUM-1:0]           on_off_i = 2'b11;
   flit_t                       data_o;
   logic                        valid_flit_o;
   logic                        busy_o;
   logic                        pkt_done_o;
   logic                        cmd_error_o;
   logic [CNT_W-1:0]            flits_sent_o;
   logic [CNT_W-1:0]            pkts_sent_o;

   exp_t exp_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   exp_seq   = 0;

   flit_injector #(
      .MAX_PKT_SIZE(MAX_PKT_SIZE), .SIZE_W(SIZE_W), .GAP_W(GAP_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .x_dest_i(x_dest_i), .y_dest_i(y_dest_i),
      .vc_i(vc_i), .pkt_size_i(pkt_size_i), .gap_i(gap_i), .on_off_i(on_off_i),
      .data_o(data_o), .valid_flit_o(valid_flit_o), .busy_o(busy_o),
      .pkt_done_o(pkt_done_o), .cmd_error_o(cmd_error_o),
      .flits_sent_o(flits_sent_o), .pkts_sent_o(pkts_sent_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected flits of one packet, worked out from index, size and sequence number.
   task automatic push_pkt(input int x, input int y, input int vc, input int size, input int seq);
      exp_t e;
      for (int i = 0; i < size; i++) begin
         e.vc   = 1'(vc);
         e.x    = 4'(x);
         e.y    = 4'(y);
         e.done = (i == size - 1);
         if (i == 0) begin
            e.label = (size == 1) ? 2'b11 : 2'b00;
            e.pl    = 16'(seq & 8'hFF);
         end else begin
            e.label = (i == size - 1) ? 2'b10 : 2'b01;
            e.pl    = 16'(i);
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic send_cmd(input int x, input int y, input int vc, input int size, input int gap);
      start_i    = 1'b1;
      x_dest_i   = 4'(x);
      y_dest_i   = 4'(y);
      vc_i       = 1'(vc);
      pkt_size_i = SIZE_W'(size);
      gap_i      = GAP_W'(gap);
      tick();
      start_i = 1'b0;
   endtask

   task automatic expect_pattern(input string name, input int n, input logic [31:0] vpat,
                                 input logic [31:0] bpat);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check($sformatf("%s_valid[%0d]", name, k), 32'(valid_flit_o), 32'(vpat[k]));
         check($sformatf("%s_busy[%0d]", name, k), 32'(busy_o), 32'(bpat[k]));
      end
   endtask

   task automatic wait_idle(input string name, input int budget, output bit err_seen);
      int k = 0;
      err_seen = 1'b0;
      while (busy_o && k < budget) begin
         @(negedge clk);
         if (cmd_error_o) err_seen = 1'b1;
         k++;
      end
      check({name, "_idle_timeout"}, 32'(busy_o), 32'd0);
      @(negedge clk);
   endtask

   // Scoreboard monitor: every valid flit must match the head of the expected queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (valid_flit_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_flit", 32'(data_o), 32'h7FFFFFFF);
            end else begin
               e = exp_q.pop_front();
               check("flit_label", 32'(data_o.flit_label), 32'(e.label));
               check("flit_vc", 32'(data_o.vc_id), 32'(e.vc));
               check("flit_done", 32'(pkt_done_o), 32'(e.done));
               if (e.label == 2'b00 || e.label == 2'b11) begin
                  check("head_pl", 32'(data_o.data.head_data.head_pl), 32'(e.pl));
                  check("head_x", 32'(data_o.data.head_data.x_dest), 32'(e.x));
                  check("head_y", 32'(data_o.data.head_data.y_dest), 32'(e.y));
               end else begin
                  check("bt_pl", 32'(data_o.data.bt_pl), 32'(e.pl));
               end
            end
         end else if (pkt_done_o) begin
            check("done_without_flit", 32'(pkt_done_o), 32'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit  err;
      int  base;

      // Reset state
      #2;
      check("rst_valid", 32'(valid_flit_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_data", 32'(data_o), 32'd0);
      check("rst_flits", 32'(flits_sent_o), 32'd0);
      check("rst_pkts", 32'(pkts_sent_o), 32'd0);
      tick();
      rst = 1'b1;
      tick();

      // Basic 4-flit packet, back-to-back
      push_pkt(2, 2, 0, 4, exp_seq); exp_seq++;
      send_cmd(2, 2, 0, 4, 0);
      expect_pattern("basic", 6, 32'b011110, 32'b001111);
      check("basic_flits", 32'(flits_sent_o), 32'd4);
      check("basic_pkts", 32'(pkts_sent_o), 32'd1);

      // Single-flit packets on VC1, sequence number advances
      push_pkt(5, 1, 1, 1, exp_seq); exp_seq++;
      send_cmd(5, 1, 1, 1, 0);
      expect_pattern("single", 3, 32'b010, 32'b001);
      push_pkt(3, 7, 1, 1, exp_seq); exp_seq++;
      send_cmd(3, 7, 1, 1, 0);
      expect_pattern("single2", 3, 32'b010, 32'b001);
      check("single_pkts", 32'(pkts_sent_o), 32'd3);

      // Inter-flit gap of 2
      push_pkt(1, 0, 0, 3, exp_seq); exp_seq++;
      send_cmd(1, 0, 0, 3, 2);
      expect_pattern("gap", 9, 32'b010010010, 32'b001111111);
      check("gap_flits", 32'(flits_sent_o), 32'd9);

      // Backpressure on VC0 for 5 cycles after the head; VC1 toggling is irrelevant
      push_pkt(4, 4, 0, 4, exp_seq); exp_seq++;
      send_cmd(4, 4, 0, 4, 0);
      tick();
      on_off_i = 2'b10;
      for (int k = 0; k < 5; k++) begin
         tick();
         on_off_i[1] = ~on_off_i[1];
         @(negedge clk);
         check($sformatf("bp_stall_valid[%0d]", k), 32'(valid_flit_o), 32'd0);
         check($sformatf("bp_stall_flits[%0d]", k), 32'(flits_sent_o), 32'd10);
      end
      on_off_i = 2'b11;
      expect_pattern("bp_resume", 4, 32'b0111, 32'b0011);
      check("bp_flits", 32'(flits_sent_o), 32'd13);

      // Illegal sizes are rejected with a one-cycle error pulse
      send_cmd(0, 0, 0, 0, 0);
      @(negedge clk);
      check("err0_pulse", 32'(cmd_error_o), 32'd1);
      check("err0_busy", 32'(busy_o), 32'd0);
      @(negedge clk);
      check("err0_clear", 32'(cmd_error_o), 32'd0);
      send_cmd(0, 0, 0, 17, 0);
      @(negedge clk);
      check("err17_pulse", 32'(cmd_error_o), 32'd1);
      check("err_no_flits", 32'(flits_sent_o), 32'd13);

      // Commands while busy are ignored without error
      push_pkt(6, 2, 0, 3, exp_seq); exp_seq++;
      send_cmd(6, 2, 0, 3, 1);
      send_cmd(0, 0, 0, 0, 0);
      send_cmd(7, 7, 1, 2, 0);
      wait_idle("ignored", 50, err);
      check("ignored_no_err", 32'(err), 32'd0);
      check("ignored_flits", 32'(flits_sent_o), 32'd16);
      check("ignored_pkts", 32'(pkts_sent_o), 32'd6);

      // Reset during a size-6 packet after its second flit
      push_pkt(2, 3, 0, 6, exp_seq);
      send_cmd(2, 3, 0, 6, 0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      exp_q.delete();
      exp_seq = 0;
      check("mid_rst_valid", 32'(valid_flit_o), 32'd0);
      check("mid_rst_busy", 32'(busy_o), 32'd0);
      check("mid_rst_data", 32'(data_o), 32'd0);
      check("mid_rst_flits", 32'(flits_sent_o), 32'd0);
      check("mid_rst_pkts", 32'(pkts_sent_o), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      push_pkt(1, 3, 0, 2, exp_seq); exp_seq++;
      send_cmd(1, 3, 0, 2, 0);
      wait_idle("post_rst", 20, err);
      check("post_rst_flits", 32'(flits_sent_o), 32'd2);
      check("post_rst_pkts", 32'(pkts_sent_o), 32'd1);

      base = exp_q.size();
      check("scoreboard_empty", 32'(base), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
